fir_decim_out: RTL and testbench

//  Output stage directly downstream of the pipelined 11-tap FIR filter.
//  - Takes the filter's 16-bit y on every clk.
//  - Discards the pipeline warm-up transient, then decimates by DECIM.
//  - Buffers the kept samples in a small FIFO.
//  - Presents them on a valid/ready stream to the slower consumer (UART/DMA).

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_decim_out_sync_fifo.sv | 58 +++++
 rtl/fir_decim_out.sv | 83 ++++++++
 tb/tb_fir_decim_out.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants and small helpers for the filter output path.
// Everything downstream of the 11-tap FIR imports this package.
package fir_pkg;

  localparam int FIR_DW     = 16;
  localparam int FIR_TAPS   = 11;
  localparam int FIR_WARMUP = 2 * FIR_TAPS;

  localparam int STREAM_VALID_W = 1;
  localparam int STREAM_READY_W = 1;

  // What happens to the current FIR sample at the decimator.
  typedef enum logic [1:0] {
    SAMPLE_SKIP,
    SAMPLE_PUSH,
    SAMPLE_DROP
  } keep_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2Min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fir_decim_out_sync_fifo.sv
// Small synchronous FIFO with register-array storage and first-word-fall-through output.
// A push while full is only accepted when a pop happens in the same cycle.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DW = FIR_DW,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic          doPush, doPop;

  assign count    = wrPtr_q - rdPtr_q;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  // Zero the output while empty so m_data reads 0 after reset or flush.
  assign pop_data = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + (AW + 1)'(1);
    if (doPop)  rdPtr_d = rdPtr_q + (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !clear && doPush) mem_q[wrPtr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: drops the filter fill transient, keeps one sample in DECIM,
// and buffers the kept samples towards a slower valid/ready consumer.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DW     = FIR_DW,
  parameter int DECIM  = 4,
  parameter int WARMUP = FIR_WARMUP,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DW-1:0]             y_in,
  input  logic                      clear,
  output logic [DW-1:0]             m_data,
  output logic [STREAM_VALID_W-1:0] m_valid,
  input  logic [STREAM_READY_W-1:0] m_ready,
  output logic [AW:0]               fifo_count,
  output logic                      ovf
);

  localparam int WCW = clog2Min1(WARMUP + 1);
  localparam int PW  = clog2Min1(DECIM);
  localparam logic [WCW-1:0] WARM_END   = WCW'(WARMUP);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(DECIM - 1);

  logic [WCW-1:0] warmCnt_q, warmCnt_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic           ovf_q, ovf_d;
  keep_e          keepAct;
  logic           popReq, fifoFull, fifoEmpty, warmDone;

  assign warmDone = (warmCnt_q == WARM_END);
  assign popReq   = m_valid[0] && m_ready[0];
  assign m_valid  = STREAM_VALID_W'(!fifoEmpty);
  assign ovf      = ovf_q;

  // Phase only runs once warm-up is done; a kept sample that finds the FIFO
  // full without a simultaneous pop is dropped but still consumes its phase.
  always_comb begin
    warmCnt_d = warmCnt_q;
    phase_d   = phase_q;
    keepAct   = SAMPLE_SKIP;
    if (warmDone) begin
      if (phase_q == '0) keepAct = (fifoFull && !popReq) ? SAMPLE_DROP : SAMPLE_PUSH;
      if (DECIM == 1 || phase_q == PHASE_LAST) phase_d = '0;
      else                                     phase_d = phase_q + PW'(1);
    end else begin
      warmCnt_d = warmCnt_q + WCW'(1);
    end
    ovf_d = ovf_q || (keepAct == SAMPLE_DROP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      warmCnt_q <= '0;
      phase_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      warmCnt_q <= warmCnt_d;
      phase_q   <= phase_d;
      ovf_q     <= ovf_d;
    end
  end

  sync_fifo #(
    .DW(DW),
    .AW(AW)
  ) uFifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (keepAct == SAMPLE_PUSH),
    .push_data (y_in),
    .pop       (popReq),
    .pop_data  (m_data),
    .count     (fifo_count),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

endmodule

// File: tb/tb_fir_decim_out.sv
// Scoreboard bench: two instances (DECIM=4 and DECIM=1) share y_in/clear/reset,
// the driver predicts kept samples into queues and a monitor checks handshakes.
module tb_fir_decim_out;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] yIn = '0;
  logic [1:0]  mReady = '0;
  logic [15:0] mData0, mData1;
  logic        mValid0, mValid1;
  logic [3:0]  fifoCount0, fifoCount1;
  logic        ovf0, ovf1;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;

  // Behavioural model state, one slot per instance.
  int          decimOf [2] = '{4, 1};
  int          warm [2] = '{0, 0};
  int          phase [2] = '{0, 0};
  int          cnt [2] = '{0, 0};
  bit          ovfM [2] = '{0, 0};
  logic [15:0] expQ [2][$];
  bit          expValid [2];
  int          expCount [2];
  bit          expOvf [2];
  bit          applyCk [2];
  bit          stall [2] = '{0, 0};
  logic [15:0] heldData [2];

  always #5 clk = ~clk;

  fir_decim_out #(.DW(16), .DECIM(4), .WARMUP(22), .DEPTH(8)) dut0 (
    .clk(clk), .reset_n(resetN), .y_in(yIn), .clear(clear),
    .m_data(mData0), .m_valid(mValid0), .m_ready(mReady[0]),
    .fifo_count(fifoCount0), .ovf(ovf0)
  );

  fir_decim_out #(.DW(16), .DECIM(1), .WARMUP(22), .DEPTH(8)) dut1 (
    .clk(clk), .reset_n(resetN), .y_in(yIn), .clear(clear),
    .m_data(mData1), .m_valid(mValid1), .m_ready(mReady[1]),
    .fifo_count(fifoCount1), .ovf(ovf1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predict what the coming rising edge does to instance i.
  task automatic modelStep(input int i, input logic [15:0] y, input logic rdy,
                           input logic clr, input logic rstn);
    bit pop, keep;
    expValid[i] = (cnt[i] > 0);
    expCount[i] = cnt[i];
    expOvf[i]   = ovfM[i];
    applyCk[i]  = rstn && !clr;
    if (!rstn || clr) begin
      warm[i] = 0; phase[i] = 0; cnt[i] = 0; ovfM[i] = 0;
      expQ[i].delete();
    end else begin
      pop  = (cnt[i] > 0) && rdy;
      keep = (warm[i] == 22) && (phase[i] == 0);
      if (keep) begin
        if (cnt[i] < 8 || pop) begin
          expQ[i].push_back(y);
          cnt[i]++;
        end else begin
          ovfM[i] = 1;
        end
      end
      if (pop) cnt[i]--;
      if (warm[i] == 22) phase[i] = (phase[i] == decimOf[i] - 1) ? 0 : phase[i] + 1;
      else               warm[i]++;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] y, input logic [1:0] rdy,
                               input logic clr, input logic rstn);
    @(negedge clk);
    yIn = y; mReady = rdy; clear = clr; resetN = rstn;
    for (int i = 0; i < 2; i++) modelStep(i, y, rdy[i], clr, rstn);
  endtask

  task automatic monitorInst(input int i, input logic v, input logic [15:0] d,
                             input logic r, input logic [3:0] c, input logic o);
    logic [15:0] e;
    checkOutput($sformatf("m_valid%0d", i), 32'(v), 32'(expValid[i]));
    checkOutput($sformatf("fifo_count%0d", i), 32'(c), 32'(expCount[i]));
    checkOutput($sformatf("ovf%0d", i), 32'(o), 32'(expOvf[i]));
    if (stall[i]) checkOutput($sformatf("stable%0d", i), 32'(d), 32'(heldData[i]));
    stall[i]    = v && !r && applyCk[i];
    heldData[i] = d;
    if (applyCk[i] && v && r) begin
      checkOutput($sformatf("queue_entry%0d", i), 32'(expQ[i].size() > 0), 32'd1);
      if (expQ[i].size() > 0) begin
        e = expQ[i].pop_front();
        checkOutput($sformatf("m_data%0d", i), 32'(d), 32'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (armed) begin
      monitorInst(0, mValid0, mData0, mReady[0], fifoCount0, ovf0);
      monitorInst(1, mValid1, mData1, mReady[1], fifoCount1, ovf1);
    end
  end

  initial begin
    applyStimulus(16'd0, 2'b00, 1'b0, 1'b0);
    armed = 1;
    applyStimulus(16'd0, 2'b00, 1'b0, 1'b0);

    // Counter ramp with a ready consumer: first kept sample is 22.
    for (int k = 0; k < 40; k++) begin
      applyStimulus(16'(k), 2'b11, 1'b0, 1'b1);
      if (k == 0) begin
        checkOutput("rst_mdata0", 32'(mData0), 32'd0);
        checkOutput("rst_mdata1", 32'(mData1), 32'd0);
      end
      if (k == 23) begin
        checkOutput("first_out0", 32'(mData0), 32'd22);
        checkOutput("first_out1", 32'(mData1), 32'd22);
      end
      if (k == 27) checkOutput("second_out0", 32'(mData0), 32'd26);
    end

    // Stall until overflow, then drain.
    applyStimulus(16'd0, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 63; k++) begin
      applyStimulus(16'(k), 2'b00, 1'b0, 1'b1);
      if (k == 51) checkOutput("fill_count0", 32'(fifoCount0), 32'd8);
      if (k == 55) begin
        checkOutput("ovf_count0", 32'(fifoCount0), 32'd8);
        checkOutput("ovf_set0", 32'(ovf0), 32'd1);
      end
    end
    for (int k = 63; k < 80; k++) applyStimulus(16'(k), 2'b11, 1'b0, 1'b1);
    checkOutput("ovf_sticky0", 32'(ovf0), 32'd1);

    // Full FIFO with ready raised exactly on a keep cycle.
    applyStimulus(16'd0, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 58; k++) begin
      applyStimulus(16'(k), (k == 54) ? 2'b11 : 2'b10, 1'b0, 1'b1);
      if (k == 55) begin
        checkOutput("keep_pop_count0", 32'(fifoCount0), 32'd8);
        checkOutput("keep_pop_ovf0", 32'(ovf0), 32'd0);
        checkOutput("keep_pop_head0", 32'(mData0), 32'd26);
      end
    end

    // Reset mid-stream with five entries queued.
    applyStimulus(16'd0, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 41; k++) begin
      applyStimulus(16'(k), 2'b10, 1'b0, 1'b1);
      if (k == 39) checkOutput("five_entries0", 32'(fifoCount0), 32'd5);
    end
    applyStimulus(16'hdead, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(16'(100 + k), 2'b11, 1'b0, 1'b1);
      if (k == 0) begin
        checkOutput("rst_valid0", 32'(mValid0), 32'd0);
        checkOutput("rst_count0", 32'(fifoCount0), 32'd0);
      end
      if (k == 23) checkOutput("post_rst_out0", 32'(mData0), 32'd122);
    end

    // Clear during a live handshake behaves like reset.
    applyStimulus(16'd0, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 33; k++) applyStimulus(16'(k), 2'b10, 1'b0, 1'b1);
    checkOutput("pre_clear_count0", 32'(fifoCount0), 32'd3);
    applyStimulus(16'hbeef, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 26; k++) begin
      applyStimulus(16'(200 + k), 2'b11, 1'b0, 1'b1);
      if (k == 0) checkOutput("clr_count0", 32'(fifoCount0), 32'd0);
      if (k == 23) checkOutput("post_clr_out0", 32'(mData0), 32'd222);
    end

    // Random data with ~30% ready duty; DECIM=1 instance overflows often.
    applyStimulus(16'd0, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 2022; k++) begin
      applyStimulus(16'($urandom_range(0, 65535)),
                    {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)},
                    1'b0, 1'b1);
    end
    for (int k = 0; k < 20; k++) applyStimulus(16'($urandom_range(0, 65535)), 2'b11, 1'b0, 1'b1);
    checkOutput("random_ovf1", 32'(ovf1), 32'd1);

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
